// File: rtl/decode_imm_sequencer_pkg.sv
// Shared decode definitions: RV32 opcode constants, immediate-format selects,
// FIFO state encoding and the decoded-entry record stored in the buffer.
package decode_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [1:0] {
    IMM_I  = 2'b00,
    IMM_S  = 2'b01,
    IMM_B  = 2'b10,
    IMM_UJ = 2'b11
  } imm_sel_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } fifo_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        uses_imm;
    logic        illegal;
  } dec_entry_t;

  // Only the 32-bit encoding space (low bits 2'b11) is decodable here.
  function automatic logic is_full_width(input logic [1:0] low_bits);
    return (low_bits == 2'b11);
  endfunction

endpackage

// File: rtl/decode_imm_sequencer_if.sv
// Fetch-side, execute-side and flush signals of the decode sequencer.
// master = fetch/execute environment, slave = the sequencer itself.
interface decode_imm_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             in_valid;
  logic [31:0]      in_instr;
  logic             in_ready;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [31:0]      out_imm;
  logic [4:0]       out_rd;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic             out_uses_imm;
  logic             out_illegal;
  logic [CNT_W-1:0] dec_count;

  modport master (
    output in_valid, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_imm, out_rd, out_rs1, out_rs2,
           out_uses_imm, out_illegal, dec_count
  );

  modport slave (
    input  in_valid, in_instr, flush, out_ready,
    output in_ready, out_valid, out_instr, out_imm, out_rd, out_rs1, out_rs2,
           out_uses_imm, out_illegal, dec_count
  );
endinterface

// File: rtl/decode_imm_sequencer_immediate_generator.sv
// Sign-extended RV32 immediate for the selected format; the U/J group is
// split on the JAL opcode so one select code serves both layouts.
import decode_pkg::*;

module immediate_generator (
  input  logic [31:0] instr,
  input  imm_sel_e    imm_sel,
  output logic [31:0] imm
);

  // Format-dependent bit gathering and sign extension
  always_comb begin
    imm = 32'd0;
    case (imm_sel)
      IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                    instr[11:8], 1'b0};
      IMM_UJ: begin
        if (instr[6:0] == OP_JAL) begin
          imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                 instr[30:21], 1'b0};
        end else begin
          imm = {instr[31:12], 12'd0};
        end
      end
      default: imm = 32'd0;
    endcase
  end

endmodule

// File: rtl/decode_imm_sequencer.sv
// Two-entry decode buffer: decodes at accept time, presents the head entry
// from registers. Define DECODE_IMM_SEQ_CNT_EN to enable the consume counter.
import decode_pkg::*;

module decode_imm_sequencer #(
  parameter int CNT_W = 32,
  parameter int DEPTH = 2
) (
  input logic                   clk,
  input logic                   rst,
  decode_imm_sequencer_if.slave bus
);

  fifo_state_e state_r;
  fifo_state_e state_next_s;
  dec_entry_t  entries_r [DEPTH];
  dec_entry_t  new_entry_s;
  imm_sel_e    imm_sel_s;
  logic [31:0] imm_raw_s;
  logic        uses_imm_s;
  logic        illegal_s;
  logic        accept_s;
  logic        consume_s;

  assign accept_s  = bus.in_valid && (state_r != ST_FULL);
  assign consume_s = (state_r != ST_EMPTY) && bus.out_ready;

  // Opcode classification into immediate format and entry flags
  always_comb begin
    imm_sel_s  = IMM_I;
    uses_imm_s = 1'b1;
    illegal_s  = 1'b0;
    if (!is_full_width(bus.in_instr[1:0])) begin
      uses_imm_s = 1'b0;
      illegal_s  = 1'b1;
    end else begin
      case (bus.in_instr[6:0])
        OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM, OP_FENCE: imm_sel_s = IMM_I;
        OP_STORE:                                      imm_sel_s = IMM_S;
        OP_BRANCH:                                     imm_sel_s = IMM_B;
        OP_LUI, OP_AUIPC, OP_JAL:                      imm_sel_s = IMM_UJ;
        OP_REG:                                        uses_imm_s = 1'b0;
        default: begin
          uses_imm_s = 1'b0;
          illegal_s  = 1'b1;
        end
      endcase
    end
  end

  immediate_generator u_imm_gen (
    .instr   (bus.in_instr),
    .imm_sel (imm_sel_s),
    .imm     (imm_raw_s)
  );

  // Assemble the record that will be written into the buffer
  always_comb begin
    new_entry_s          = '0;
    new_entry_s.instr    = bus.in_instr;
    new_entry_s.imm      = uses_imm_s ? imm_raw_s : 32'd0;
    new_entry_s.rd       = bus.in_instr[11:7];
    new_entry_s.rs1      = bus.in_instr[19:15];
    new_entry_s.rs2      = bus.in_instr[24:20];
    new_entry_s.uses_imm = uses_imm_s;
    new_entry_s.illegal  = illegal_s;
  end

  // FIFO occupancy register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Occupancy transitions; flush overrides any accept or consume
  always_comb begin
    state_next_s = state_r;
    if (bus.flush) begin
      state_next_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_next_s = ST_ONE;
          end else begin
            state_next_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && !consume_s) begin
            state_next_s = ST_FULL;
          end else if (!accept_s && consume_s) begin
            state_next_s = ST_EMPTY;
          end else begin
            state_next_s = ST_ONE;
          end
        end
        ST_FULL: begin
          if (consume_s) begin
            state_next_s = ST_ONE;
          end else begin
            state_next_s = ST_FULL;
          end
        end
        default: state_next_s = ST_EMPTY;
      endcase
    end
  end

  // Entry storage; slot 0 is always the head, slot 1 the follower
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i] <= '0;
      end
    end else if (!bus.flush) begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            entries_r[0] <= new_entry_s;
          end
        end
        ST_ONE: begin
          if (accept_s && consume_s) begin
            entries_r[0] <= new_entry_s;
          end else if (accept_s) begin
            entries_r[1] <= new_entry_s;
          end
        end
        ST_FULL: begin
          if (consume_s) begin
            entries_r[0] <= entries_r[1];
          end
        end
        default: begin
          entries_r[0] <= entries_r[0];
        end
      endcase
    end
  end

  assign bus.in_ready     = (state_r != ST_FULL);
  assign bus.out_valid    = (state_r != ST_EMPTY);
  assign bus.out_instr    = entries_r[0].instr;
  assign bus.out_imm      = entries_r[0].imm;
  assign bus.out_rd       = entries_r[0].rd;
  assign bus.out_rs1      = entries_r[0].rs1;
  assign bus.out_rs2      = entries_r[0].rs2;
  assign bus.out_uses_imm = entries_r[0].uses_imm;
  assign bus.out_illegal  = entries_r[0].illegal;

`ifdef DECODE_IMM_SEQ_CNT_EN
  logic [CNT_W-1:0] dec_count_r;

  // Consumed-entry counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_count_r <= '0;
    end else if (!bus.flush && consume_s) begin
      dec_count_r <= dec_count_r + CNT_W'(1);
    end
  end

  assign bus.dec_count = dec_count_r;
`else
  assign bus.dec_count = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/decode_imm_sequencer.md
DECODE_IMM_SEQUENCER -- requirements
Module: decode_imm_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the decoded-instruction counter.
REQ-002 SHALL have parameter DEPTH, fixed at 2, number of decode buffer entries.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, fetch offers an instruction.
REQ-006 SHALL have port in_instr, input, 32, the fetched instruction word.
REQ-007 SHALL have port in_ready, output, 1, the block accepts an instruction this cycle.
REQ-008 SHALL have port flush, input, 1, discard all buffered and incoming instructions.
REQ-009 SHALL have port out_valid, output, 1, a decoded entry is presented.
REQ-010 SHALL have port out_ready, input, 1, execute consumes the presented entry.
REQ-011 SHALL have ports out_instr (32), out_imm (32), out_rd (5), out_rs1 (5), out_rs2 (5), all outputs, holding the head entry's fields.
REQ-012 SHALL have ports out_uses_imm (1) and out_illegal (1), both outputs, holding the head entry's flags.
REQ-013 SHALL have port dec_count, output, CNT_W, the number of entries consumed.

Function
REQ-014 SHALL be a 2-entry FIFO with states EMPTY, ONE and FULL; in_ready = (state != FULL); out_valid = (state != EMPTY).
REQ-015 SHALL accept on in_valid&&in_ready and consume on out_valid&&out_ready.
REQ-016 SHALL transition EMPTY->ONE on accept; ONE->FULL on accept without consume; ONE->EMPTY on consume without accept; FULL->ONE on consume; ONE stays ONE when accept and consume coincide.
REQ-017 SHALL present an accepted instruction on the outputs the next cycle (latency 1); an instruction accepted into an empty buffer is visible at the head immediately on that edge.
REQ-018 SHALL decode at accept time and store decoded fields; head outputs SHALL be registered and SHALL stay stable while out_valid&&!out_ready.
REQ-019 SHALL map opcode[6:0] to imm_sel: 0000011, 0010011, 1100111, 1110011, 0001111 -> I (00); 0100011 -> S (01); 1100011 -> B (10); 0110111, 0010111, 1101111 -> U/J (11).
REQ-020 SHALL set out_uses_imm=0 and out_imm=0 for opcode 0110011.
REQ-021 SHALL set out_illegal=1, out_uses_imm=0 and out_imm=0 for any other opcode, or when instr[1:0] != 2'b11; illegal entries flow through the FIFO normally.
REQ-022 SHALL extract rd=[11:7], rs1=[19:15] and rs2=[24:20] unconditionally.
REQ-023 SHALL, on flush, go to EMPTY on the next edge, drop any same-cycle accept and increment nothing; flush has priority over accept and consume.
REQ-024 SHALL drive in_ready from state only, with no combinational path from out_ready.

Reset
REQ-025 SHALL, with rst high at an edge, set state=EMPTY, out_valid=0, in_ready=1, all out_* data fields=0 and dec_count=0.
REQ-026 SHALL discard buffered entries on reset mid-operation, with no partial consume counted; rst has priority over flush.

Configuration
REQ-027 SHALL support macro DECODE_IMM_SEQ_CNT_EN: when defined, dec_count increments by 1 per consume and wraps modulo 2^CNT_W.
REQ-028 SHALL, when DECODE_IMM_SEQ_CNT_EN is undefined, keep the dec_count port and tie it to 0 with no counter register.

Structure
REQ-029 SHALL take the opcode constants, imm_sel encodings (IMM_I/S/B/UJ) and the decoded-entry struct from shared package decode_pkg.
REQ-030 SHALL instantiate exactly one immediate_generator sub-module on the accept path, driven by in_instr and the derived imm_sel.

Verification
REQ-031 SHALL check: in_instr=0xFFF00093 accepted, out_ready=1 -> next cycle out_imm=0xFFFFFFFF, rd=1, rs1=0, out_uses_imm=1, out_illegal=0.
REQ-032 SHALL check: 0x12345037 then 0x008000EF back-to-back -> out_imm=0x12345000, then out_imm=0x00000008, rd=1.
REQ-033 SHALL check: out_ready=0 with 3 valid offers -> 2 accepted, in_ready=0 at FULL, head stable; after release the order is preserved with no loss or duplicate.
REQ-034 SHALL check: in_instr=0x00000000 -> out_illegal=1, out_imm=0; 0x002081B3 -> out_uses_imm=0, rd=3, rs1=1, rs2=2.
REQ-035 SHALL check: FULL plus flush asserted with in_valid=1 -> EMPTY next cycle, out_valid=0, dec_count unchanged.
REQ-036 SHALL check: with the macro defined, 5 consumes -> dec_count=5; rst mid-stream -> dec_count=0, state EMPTY.
